// File: rtl/uart_tx_req_arbiter.sv
// rtl/uart_tx_req_arbiter.sv - packet-granular round-robin arbiter in front of the UART tx FIFO write port
module uart_tx_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        Req_i,
    input  logic [NUM_REQ*DATA_W-1:0] Data_i,
    input  logic [NUM_REQ-1:0]        Last_i,
    output logic [NUM_REQ-1:0]        Ack_o,
    output logic [NUM_REQ-1:0]        Grant_o,
    input  logic                      FifoFull_i,
    output logic                      FifoWrEn_o,
    output logic [DATA_W-1:0]         FifoData_o,
    output logic                      Busy_o
);
    localparam int               IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_ARB     = 4'b0010,
        S_XFER    = 4'b0100,
        S_RELEASE = 4'b1000
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [7:0]         burst_cnt;

    logic               owner_req;
    logic               wr;
    logic               done;
    logic [IDX_W:0]     scan;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_hit;

    // First requester at or above ptr, wrapping back to channel 0.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        scan    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!arb_hit && Req_i[scan[IDX_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = scan[IDX_W-1:0];
            end
        end
    end

    assign owner_req = Req_i[owner];
    assign wr        = (state == S_XFER) && owner_req && !FifoFull_i;
    // Last_i and the burst limit on the same write collapse into one exit.
    assign done      = !owner_req || (wr && (Last_i[owner] || (burst_cnt == BURST_LAST)));

    assign Ack_o      = wr ? grant : '0;
    assign FifoWrEn_o = wr;
    assign FifoData_o = wr ? Data_i[owner*DATA_W +: DATA_W] : '0;
    assign Grant_o    = grant;
    assign Busy_o     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|Req_i) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (arb_hit) begin
                        grant     <= NUM_REQ'(1) << arb_idx;
                        owner     <= arb_idx;
                        burst_cnt <= '0;
                        state     <= S_XFER;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (wr) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    if (done) begin
                        grant <= '0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    ptr   <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_req_arbiter.sv
// tb/tb_uart_tx_req_arbiter.sv - directed and randomized self-checking bench for uart_tx_req_arbiter
module tb_uart_tx_req_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;

    logic                      clk        = 1'b0;
    logic                      rst        = 1'b0;
    logic [NUM_REQ-1:0]        Req_i      = '0;
    logic [NUM_REQ*DATA_W-1:0] Data_i     = '0;
    logic [NUM_REQ-1:0]        Last_i     = '0;
    logic                      FifoFull_i = 1'b0;
    logic [NUM_REQ-1:0]        Ack_o;
    logic [NUM_REQ-1:0]        Grant_o;
    logic                      FifoWrEn_o;
    logic [DATA_W-1:0]         FifoData_o;
    logic                      Busy_o;

    uart_tx_req_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Req_i     (Req_i),
        .Data_i    (Data_i),
        .Last_i    (Last_i),
        .Ack_o     (Ack_o),
        .Grant_o   (Grant_o),
        .FifoFull_i(FifoFull_i),
        .FifoWrEn_o(FifoWrEn_o),
        .FifoData_o(FifoData_o),
        .Busy_o    (Busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-channel packet queues: the requesters and the reference model share them.
    logic [DATA_W-1:0]  q_data [NUM_REQ][$];
    logic               q_last [NUM_REQ][$];
    logic [NUM_REQ-1:0] want     = '0;
    logic               full     = 1'b0;
    logic [NUM_REQ-1:0] ack_seen = '0;
    bit                 rand_mode   = 1'b0;
    bit                 auto_refill = 1'b0;

    int                 m_ptr       = 0;
    int                 m_owner     = -1;
    int                 m_cnt       = 0;
    bit                 exp_release = 1'b0;
    logic [NUM_REQ-1:0] req_prev    = '0;
    int                 seg_ch[$];
    int                 seg_len[$];
    int                 gstart_ch[$];
    int                 gstart_cyc[$];
    int                 cyc       = 0;
    int                 n_pushed  = 0;
    int                 n_written = 0;
    int                 exp_seg_ch[5]  = '{2, 0, 2, 0, 2};
    int                 exp_seg_len[5] = '{16, 2, 16, 2, 8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int ch = 0; ch < NUM_REQ; ch++) s += q_data[ch].size();
        return s;
    endfunction

    task automatic push_pkt(input int ch, input int len, input logic [DATA_W-1:0] base);
        for (int i = 0; i < len; i++) begin
            q_data[ch].push_back(base + DATA_W'(i));
            q_last[ch].push_back(i == len - 1);
        end
        n_pushed += len;
    endtask

    task automatic drive();
        for (int ch = 0; ch < NUM_REQ; ch++) begin
            Req_i[ch] = want[ch] && (q_data[ch].size() > 0);
            Data_i[ch*DATA_W +: DATA_W] = Req_i[ch] ? q_data[ch][0] : '0;
            Last_i[ch] = Req_i[ch] ? q_last[ch][0] : 1'b0;
        end
        FifoFull_i = full;
    endtask

    task automatic agent();
        for (int ch = 0; ch < NUM_REQ; ch++) begin
            if (ack_seen[ch] && q_data[ch].size() > 0) begin
                void'(q_data[ch].pop_front());
                void'(q_last[ch].pop_front());
            end
            if (auto_refill && q_data[ch].size() == 0) push_pkt(ch, 1, DATA_W'(32'hC0 + ch));
            if (rand_mode) begin
                if (q_data[ch].size() == 0 && $urandom_range(0, 7) == 0)
                    push_pkt(ch, int'($urandom_range(1, 40)), DATA_W'($urandom));
                if (!want[ch])
                    want[ch] = (q_data[ch].size() > 0) && ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 31) == 0)
                    want[ch] = 1'b0;
            end
        end
        if (rand_mode) full = ($urandom_range(0, 3) == 0);
    endtask

    // Grant-level reference: who should own the port, what byte it writes, when it must let go.
    task automatic scoreboard();
        int owner;
        bit wr_exp;
        cyc++;
        ack_seen = Ack_o;
        check("grant_onehot", 32'($countones(Grant_o) <= 1), 32'd1);
        if (m_owner >= 0) begin
            check("grant_release", 32'(Grant_o == '0), 32'(exp_release));
            if (Grant_o == '0) begin
                check("burst_cap", 32'(m_cnt <= MAX_BURST), 32'd1);
                seg_ch.push_back(m_owner);
                seg_len.push_back(m_cnt);
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
            end
        end
        if (Grant_o != '0) begin
            owner = onehot_idx(Grant_o);
            check("busy_with_grant", 32'(Busy_o), 32'd1);
            if (m_owner < 0) begin
                check("rr_owner", owner, rr_pick(req_prev, m_ptr));
                gstart_ch.push_back(owner);
                gstart_cyc.push_back(cyc);
                m_owner = owner;
                m_cnt   = 0;
            end else begin
                check("grant_held", owner, m_owner);
            end
            wr_exp = Req_i[m_owner] && !FifoFull_i;
            check("wr_en", 32'(FifoWrEn_o), 32'(wr_exp));
            if (wr_exp) begin
                m_cnt++;
                n_written++;
                check("wr_data", 32'(FifoData_o), 32'(q_data[m_owner][0]));
                check("ack_owner", 32'(Ack_o), 32'(1 << m_owner));
                exp_release = q_last[m_owner][0] || (m_cnt == MAX_BURST);
            end else begin
                check("ack_nowr", 32'(Ack_o), 0);
                check("data_nowr", 32'(FifoData_o), 0);
                exp_release = !Req_i[m_owner];
            end
        end else begin
            check("wr_en_idle", 32'(FifoWrEn_o), 0);
            check("ack_idle", 32'(Ack_o), 0);
            check("data_idle", 32'(FifoData_o), 0);
            exp_release = 1'b0;
        end
        req_prev = Req_i;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        agent();
        drive();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        want = '0;
        full = 1'b0;
        rand_mode = 1'b0;
        auto_refill = 1'b0;
        ack_seen = '0;
        for (int ch = 0; ch < NUM_REQ; ch++) begin
            q_data[ch].delete();
            q_last[ch].delete();
        end
        drive();
        m_ptr = 0; m_owner = -1; m_cnt = 0; exp_release = 1'b0; req_prev = '0;
        seg_ch.delete(); seg_len.delete(); gstart_ch.delete(); gstart_cyc.delete();
        n_pushed = 0; n_written = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(Grant_o), 0);
        check("rst_ack", 32'(Ack_o), 0);
        check("rst_wren", 32'(FifoWrEn_o), 0);
        check("rst_data", 32'(FifoData_o), 0);
        check("rst_busy", 32'(Busy_o), 0);
        rst = 1'b1;
    endtask

    task automatic wait_segs(input string tag, input int n, input int limit);
        int k = 0;
        while (seg_ch.size() < n && k < limit) begin
            step();
            k++;
        end
        check(tag, 32'(seg_ch.size() >= n), 32'd1);
    endtask

    initial begin
        int k;

        // Single packet: latency and cycle-exact framing
        do_reset();
        step();
        push_pkt(1, 3, 8'hA1);
        want[1] = 1'b1;
        step();
        check("single_c0_busy", 32'(Busy_o), 0);
        step();
        check("single_c1_busy", 32'(Busy_o), 1);
        check("single_c1_grant", 32'(Grant_o), 0);
        check("single_c1_wren", 32'(FifoWrEn_o), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("single_wren", 32'(FifoWrEn_o), 1);
            check("single_data", 32'(FifoData_o), 32'hA1 + i);
            check("single_ack", 32'(Ack_o), 32'b0010);
            check("single_grant", 32'(Grant_o), 32'b0010);
        end
        step();
        check("single_c5_grant", 32'(Grant_o), 0);
        check("single_c5_busy", 32'(Busy_o), 1);
        step();
        check("single_c6_busy", 32'(Busy_o), 0);

        // Round robin with 1-byte packets on all channels
        do_reset();
        auto_refill = 1'b1;
        for (int ch = 0; ch < NUM_REQ; ch++) push_pkt(ch, 1, DATA_W'(32'hC0 + ch));
        want = '1;
        wait_segs("rr_segs", 5, 60);
        if (seg_ch.size() >= 5 && gstart_cyc.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("rr_order", seg_ch[i], i % NUM_REQ);
                check("rr_len", seg_len[i], 1);
            end
            for (int i = 0; i < 4; i++) check("rr_gap", gstart_cyc[i+1] - gstart_cyc[i], 4);
        end

        // Backpressure mid-packet
        do_reset();
        push_pkt(0, 8, 8'h10);
        want[0] = 1'b1;
        k = 0;
        while (!(m_owner == 0 && m_cnt == 3) && k < 20) begin
            step();
            k++;
        end
        check("bp_reach", 32'(m_owner == 0 && m_cnt == 3), 1);
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_no_wr", 32'(FifoWrEn_o), 0);
            check("bp_no_ack", 32'(Ack_o), 0);
            check("bp_grant_held", 32'(Grant_o), 32'b0001);
        end
        full = 1'b0;
        wait_segs("bp_done", 1, 40);
        if (seg_len.size() >= 1) check("bp_len", seg_len[0], 8);

        // Burst limit interleaving a long packet with a waiting channel
        do_reset();
        push_pkt(2, 40, 8'h40);
        want[2] = 1'b1;
        k = 0;
        while (gstart_ch.size() < 1 && k < 20) begin
            step();
            k++;
        end
        for (int i = 0; i < 3; i++) push_pkt(0, 2, DATA_W'(32'h20 + 2 * i));
        want[0] = 1'b1;
        wait_segs("burst_segs", 5, 400);
        if (seg_ch.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("burst_ch", seg_ch[i], exp_seg_ch[i]);
                check("burst_len", seg_len[i], exp_seg_len[i]);
            end
        end

        // Owner withdraws mid-packet
        do_reset();
        push_pkt(1, 5, 8'h60);
        want[1] = 1'b1;
        k = 0;
        while (!(m_owner == 1 && m_cnt == 2) && k < 20) begin
            step();
            k++;
        end
        want[1] = 1'b0;
        step();
        check("wd_hold_grant", 32'(Grant_o), 32'b0010);
        check("wd_no_wr", 32'(FifoWrEn_o), 0);
        step();
        check("wd_released", 32'(Grant_o), 0);
        check("wd_busy", 32'(Busy_o), 1);
        push_pkt(3, 1, 8'h70);
        want[1] = 1'b1;
        want[3] = 1'b1;
        wait_segs("wd_drain", 3, 60);
        if (gstart_ch.size() >= 2 && seg_len.size() >= 3) begin
            check("wd_ptr_adv", gstart_ch[1], 3);
            check("wd_resume_len", seg_len[2], 3);
        end

        // Reset mid-XFER
        do_reset();
        push_pkt(1, 1, 8'h80);
        want[1] = 1'b1;
        wait_segs("rst_pre", 1, 20);
        push_pkt(1, 10, 8'h90);
        k = 0;
        while (!(m_owner == 1 && m_cnt >= 2) && k < 30) begin
            step();
            k++;
        end
        check("rst_reach", 32'(m_owner == 1 && m_cnt >= 2), 1);
        rst = 1'b0;
        #1;
        check("rst_async_grant", 32'(Grant_o), 0);
        check("rst_async_wren", 32'(FifoWrEn_o), 0);
        check("rst_async_ack", 32'(Ack_o), 0);
        do_reset();
        push_pkt(0, 1, 8'hB0);
        push_pkt(3, 1, 8'hB3);
        want = 4'b1001;
        k = 0;
        while (gstart_ch.size() < 1 && k < 20) begin
            step();
            k++;
        end
        if (gstart_ch.size() >= 1) check("rst_ptr_zero", gstart_ch[0], 0);
        else check("rst_grant_seen", 0, 1);

        // Randomized traffic with backpressure and withdrawals
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        full = 1'b0;
        want = '1;
        k = 0;
        while ((pending() > 0 || m_owner >= 0) && k < 4000) begin
            step();
            k++;
        end
        check("rand_drained", pending(), 0);
        check("rand_bytes", n_written, n_pushed);
        check("rand_activity", 32'(seg_ch.size() > 10), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
